// File: rtl/launcher_pkg.sv
// launcher_pkg: shared state encoding and sizing constants for the program launcher
package launcher_pkg;
  typedef enum logic [2:0] {IDLE, PULSE, RUN, GAP, FINISH} state_t;
  localparam int PROG_IDW = 2;
  localparam int MAX_PROGS = 4;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with sync clear, enable and saturation limit
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] lim,
  output logic [W-1:0] q
);
  logic [W-1:0] q_d, q_q;
  always_comb q_d = clr ? '0 : (en && q_q < lim) ? q_q + 1'b1 : q_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) q_q <= '0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/prog_launcher.sv
// prog_launcher: issues one START pulse per program, waits for HALT and reports the cycle count,
// stepping through NUM_PROGS programs before flagging completion.
module prog_launcher
  import launcher_pkg::*;
#(
  parameter int NUM_PROGS = 3,
  parameter int START_CYCLES = 2,
  parameter int CNTW = 16,
  parameter logic [CNTW-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                GO,
  input  logic                HALT,
  output logic                START,
  output logic [PROG_IDW-1:0] PROG_ID,
  output logic                BUSY,
  output logic                CYC_VALID,
  output logic [CNTW-1:0]     CYC_COUNT,
  output logic                DONE_ALL,
  output logic                TIMEOUT_ERR
);
  localparam logic [CNTW-1:0] PULSE_LAST = CNTW'(START_CYCLES - 1);
  localparam logic [PROG_IDW-1:0] LAST_ID = PROG_IDW'(NUM_PROGS - 1);
  state_t state_q, state_d;
  logic [PROG_IDW-1:0] pid_q, pid_d;
  logic [CNTW-1:0] count_q, count_d, pcnt, ccnt;
  logic armed_q, armed_d, start_q, start_d, busy_q, busy_d;
  logic valid_q, valid_d, done_q, done_d, err_q, err_d;
  logic go_ok, complete, expire, last;
  assign go_ok = GO && (state_q == IDLE || state_q == FINISH);
  assign complete = state_q == RUN && armed_q && HALT;
  assign expire = state_q == RUN && !complete && ccnt == TIMEOUT;
  assign last = pid_q == LAST_ID;
  sat_counter #(.W(CNTW)) u_pulse (
    .clk(CLK), .rst(RESET), .clr(state_q != PULSE), .en(state_q == PULSE), .lim(PULSE_LAST), .q(pcnt)
  );
  sat_counter #(.W(CNTW)) u_cycle (
    .clk(CLK), .rst(RESET), .clr(state_q != RUN), .en(state_q == RUN), .lim(TIMEOUT), .q(ccnt)
  );
  always_comb begin
    state_d = state_q;
    if (go_ok) state_d = PULSE;
    else if (state_q == PULSE && pcnt == PULSE_LAST) state_d = RUN;
    else if (complete) state_d = last ? FINISH : GAP;
    else if (expire) state_d = FINISH;
    else if (state_q == GAP) state_d = PULSE;
    pid_d = go_ok ? '0 : (complete && !last) ? pid_q + 1'b1 : pid_q;
    // arming needs a HALT=0 cycle inside this run, so a leftover HALT cannot end it early
    armed_d = state_q == RUN && (armed_q || !HALT);
    count_d = (complete || expire) ? ccnt : count_q;
    valid_d = complete || expire;
    err_d = go_ok ? 1'b0 : err_q || expire;
    start_d = state_d == PULSE;
    busy_d = state_d != IDLE && state_d != FINISH;
    done_d = state_d == FINISH;
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state_q <= IDLE;
      pid_q <= '0;
      count_q <= '0;
      armed_q <= 1'b0;
      start_q <= 1'b0;
      busy_q <= 1'b0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pid_q <= pid_d;
      count_q <= count_d;
      armed_q <= armed_d;
      start_q <= start_d;
      busy_q <= busy_d;
      valid_q <= valid_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  assign START = start_q;
  assign PROG_ID = pid_q;
  assign BUSY = busy_q;
  assign CYC_VALID = valid_q;
  assign CYC_COUNT = count_q;
  assign DONE_ALL = done_q;
  assign TIMEOUT_ERR = err_q;
endmodule

// File: tb/tb_prog_launcher.sv
// tb_prog_launcher: randomized launch sequences checked cycle by cycle against a timeline model
module tb_prog_launcher;
  localparam int NP = 3, SC = 2, TO = 20;
  logic clk = 1'b0, rst = 1'b1, go = 1'b0, halt = 1'b0;
  logic start, busy, valid, done, err;
  logic [1:0] pid;
  logic [15:0] cnt;
  int tests = 0, fails = 0, prev_cnt = 0;
  int ps[NP], ph[NP];
  bit go_noise = 1'b0;

  prog_launcher #(.NUM_PROGS(NP), .START_CYCLES(SC), .CNTW(16), .TIMEOUT(16'd20)) dut (
    .CLK(clk), .RESET(rst), .GO(go), .HALT(halt), .START(start), .PROG_ID(pid), .BUSY(busy),
    .CYC_VALID(valid), .CYC_COUNT(cnt), .DONE_ALL(done), .TIMEOUT_ERR(err)
  );

  always #5 clk = ~clk;

  // HALT level seen by program p in its i-th RUN cycle: stale for ps cycles, low, then high from ph on
  function automatic bit hf(int p, int i);
    return (i < ps[p]) || (i >= ph[p]);
  endfunction

  // RUN cycle at which program p completes, or -1 if it reaches the timeout first
  function automatic int fd(int p);
    bit armed = 1'b0;
    for (int i = 0; i <= TO; i++) begin
      if (armed && hf(p, i)) return i;
      if (!hf(p, i)) armed = 1'b1;
    end
    return -1;
  endfunction

  task automatic run_seq(input string tag);
    int pst[NP], vc[NP], kk[NP];
    int k, last, f, c0, ep;
    bit tout;
    logic es, ev;
    logic [15:0] ec;
    c0 = 0; tout = 1'b0; last = NP - 1;
    for (int p = 0; p < NP; p++) begin
      k = fd(p);
      pst[p] = c0;
      kk[p] = k < 0 ? TO : k;
      vc[p] = c0 + SC + kk[p] + 1;
      c0 = vc[p] + 1;
      if (k < 0) begin tout = 1'b1; last = p; break; end
    end
    f = vc[last];
    go = 1'b1;
    halt = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    for (int c = 0; c <= f + 2; c++) begin
      es = 1'b0; ev = 1'b0; ep = 0; ec = 16'(prev_cnt);
      for (int p = 0; p <= last; p++) begin
        if (c >= pst[p] && c < pst[p] + SC) es = 1'b1;
        if (c == vc[p]) ev = 1'b1;
        if (c >= vc[p]) begin
          ec = 16'(kk[p]);
          if (p < last) ep = p + 1;
        end
      end
      tests += 7;
      if (start !== es) begin fails++; $display("FAIL %s start c=%0d got %b exp %b", tag, c, start, es); end
      if (pid !== 2'(ep)) begin fails++; $display("FAIL %s prog_id c=%0d got %0d exp %0d", tag, c, pid, ep); end
      if (busy !== (c < f)) begin fails++; $display("FAIL %s busy c=%0d got %b exp %b", tag, c, busy, c < f); end
      if (valid !== ev) begin fails++; $display("FAIL %s cyc_valid c=%0d got %b exp %b", tag, c, valid, ev); end
      if (cnt !== ec) begin fails++; $display("FAIL %s cyc_count c=%0d got %0d exp %0d", tag, c, cnt, ec); end
      if (done !== (c >= f)) begin fails++; $display("FAIL %s done_all c=%0d got %b exp %b", tag, c, done, c >= f); end
      if (err !== (tout && c >= f)) begin fails++; $display("FAIL %s timeout_err c=%0d got %b exp %b", tag, c, err, tout && c >= f); end
      go = (go_noise && c < f) ? 1'($urandom_range(0, 1)) : 1'b0;
      halt = 1'($urandom_range(0, 1));
      for (int p = 0; p <= last; p++)
        if (c >= pst[p] + SC && c < vc[p]) halt = hf(p, c - pst[p] - SC);
      @(posedge clk); #1;
    end
    prev_cnt = kk[last];
  endtask

  task automatic test_reset;
    rst = 1'b1; go = 1'b0; halt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests += 7;
    if (start !== 1'b0) begin fails++; $display("FAIL reset start got %b exp 0", start); end
    if (pid !== 2'd0) begin fails++; $display("FAIL reset prog_id got %0d exp 0", pid); end
    if (busy !== 1'b0) begin fails++; $display("FAIL reset busy got %b exp 0", busy); end
    if (valid !== 1'b0) begin fails++; $display("FAIL reset cyc_valid got %b exp 0", valid); end
    if (cnt !== 16'd0) begin fails++; $display("FAIL reset cyc_count got %0d exp 0", cnt); end
    if (done !== 1'b0) begin fails++; $display("FAIL reset done_all got %b exp 0", done); end
    if (err !== 1'b0) begin fails++; $display("FAIL reset timeout_err got %b exp 0", err); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    prev_cnt = 0;
  endtask

  task automatic test_basic;
    go_noise = 1'b0;
    for (int p = 0; p < NP; p++) begin ps[p] = 0; ph[p] = 10; end
    run_seq("basic");
  endtask

  task automatic test_stale;
    go_noise = 1'b0;
    ps[0] = 3; ph[0] = 7; ps[1] = 0; ph[1] = 5; ps[2] = 2; ph[2] = 9;
    run_seq("stale_halt");
  endtask

  task automatic test_timeout;
    go_noise = 1'b0;
    for (int p = 0; p < NP; p++) begin ps[p] = 0; ph[p] = 1000; end
    run_seq("timeout");
  endtask

  task automatic test_restart;
    go_noise = 1'b1;
    ps[0] = 1; ph[0] = 4; ps[1] = 0; ph[1] = 12; ps[2] = 2; ph[2] = 3;
    run_seq("restart");
  endtask

  task automatic test_simultaneous;
    go_noise = 1'b0;
    ps[0] = 0; ph[0] = TO; ps[1] = 0; ph[1] = 4; ps[2] = 1; ph[2] = 6;
    run_seq("halt_at_timeout");
  endtask

  task automatic test_random;
    go_noise = 1'b1;
    for (int n = 0; n < 8; n++) begin
      for (int p = 0; p < NP; p++) begin
        ps[p] = int'($urandom_range(0, 4));
        ph[p] = ps[p] + 1 + int'($urandom_range(0, 20));
        if ($urandom_range(0, 7) == 0) begin ps[p] = 0; ph[p] = 0; end
      end
      run_seq("random");
    end
  endtask

  task automatic test_reset_mid;
    go = 1'b1; halt = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 10; c++) begin
      go = 1'b0;
      halt = c >= 7;
      @(posedge clk); #1;
    end
    tests += 2;
    if (start !== 1'b1) begin fails++; $display("FAIL reset_mid pre start got %b exp 1", start); end
    if (pid !== 2'd1) begin fails++; $display("FAIL reset_mid pre prog_id got %0d exp 1", pid); end
    rst = 1'b1;
    #1;
    tests += 7;
    if (start !== 1'b0) begin fails++; $display("FAIL reset_mid start got %b exp 0", start); end
    if (pid !== 2'd0) begin fails++; $display("FAIL reset_mid prog_id got %0d exp 0", pid); end
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_mid busy got %b exp 0", busy); end
    if (valid !== 1'b0) begin fails++; $display("FAIL reset_mid cyc_valid got %b exp 0", valid); end
    if (cnt !== 16'd0) begin fails++; $display("FAIL reset_mid cyc_count got %0d exp 0", cnt); end
    if (done !== 1'b0) begin fails++; $display("FAIL reset_mid done_all got %b exp 0", done); end
    if (err !== 1'b0) begin fails++; $display("FAIL reset_mid timeout_err got %b exp 0", err); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    prev_cnt = 0;
    go_noise = 1'b0;
    for (int p = 0; p < NP; p++) begin ps[p] = 0; ph[p] = 10; end
    run_seq("after_reset");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stale;
    test_timeout;
    test_restart;
    test_simultaneous;
    test_random;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
